camac_cycle_sequencer: RTL

CAMAC_CYCLE_SEQUENCER -- requirements
Module: camac_cycle_sequencer

---
 rtl/sm2201_camac_pkg.sv | 34 +++
 rtl/camac_cycle_timer.sv | 28 ++
 rtl/camac_cycle_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sm2201_camac_pkg.sv
// Shared CAMAC definitions: field widths, default cycle timing and the
// sequencer state encoding.
package sm2201_camac_pkg;

    localparam int unsigned CRATE_W   = 3;
    localparam int unsigned STATION_W = 5;
    localparam int unsigned SUBADDR_W = 4;
    localparam int unsigned FUNC_W    = 5;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = CRATE_W + STATION_W + SUBADDR_W;
    localparam int unsigned TMR_W     = 16;

    localparam int unsigned DEF_T_SETUP = 2;
    localparam int unsigned DEF_T_S1    = 4;
    localparam int unsigned DEF_T_GAP   = 2;
    localparam int unsigned DEF_T_S2    = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_WAIT_X = 3'd2,
        ST_S1     = 3'd3,
        ST_GAP    = 3'd4,
        ST_S2     = 3'd5,
        ST_DONE   = 3'd6
    } camac_state_t;

    // A state lasting N cycles loads N-1 so the terminal count marks its last cycle.
    function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/camac_cycle_timer.sv
// Per-state down-counter: loads on state entry, counts down to zero and
// flags the last cycle of the state with tc.
module camac_cycle_timer
    import sm2201_camac_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] load_value,
    output logic             tc
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/camac_cycle_sequencer.sv
// CAMAC dataway cycle sequencer: ISA-side request -> SETUP/X/S1/GAP/S2 -> response.
// Optional WAIT_X timeout enabled by defining CAMAC_SEQ_TIMEOUT_EN.
module camac_cycle_sequencer
    import sm2201_camac_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_S1    = DEF_T_S1,
    parameter int unsigned T_GAP   = DEF_T_GAP,
    parameter int unsigned T_S2    = DEF_T_S2,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 isa_clk,
    input  logic                 isa_reset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [CRATE_W-1:0]   req_crate,
    input  logic [STATION_W-1:0] req_station,
    input  logic [SUBADDR_W-1:0] req_subaddr,
    input  logic [FUNC_W-1:0]    req_func,
    input  logic [DATA_W-1:0]    req_wdata,

    output logic [ADDR_W-1:0]    cb_addr,
    output logic [FUNC_W-1:0]    cb_func,
    output logic [DATA_W-1:0]    cb_data_out,
    output logic                 cb_data_oe,
    input  logic [DATA_W-1:0]    cb_data_in,
    output logic                 cb_s1,
    output logic                 cb_s2,
    input  logic                 cb_prr,
    input  logic                 cb_zk4,

    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_x,
    output logic                 rsp_q,
    output logic                 rsp_timeout,
    output logic                 isa_chrdy
);

    camac_state_t     state, next_state;
    logic             tc;
    logic             tmr_load_en;
    logic [TMR_W-1:0] tmr_load_value;
    logic             accept;

    logic [ADDR_W-1:0] addr_q;
    logic [FUNC_W-1:0] func_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;

    assign accept = (state == ST_IDLE) && req_valid;

    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (req_valid) next_state = ST_SETUP;
            ST_SETUP:  if (tc) next_state = ST_WAIT_X;
            ST_WAIT_X: begin
                if (!cb_prr) begin
                    next_state = ST_S1;
                end
`ifdef CAMAC_SEQ_TIMEOUT_EN
                else if (tc) begin
                    next_state = ST_DONE;
                end
`endif
            end
            ST_S1:     if (tc) next_state = ST_GAP;
            ST_GAP:    if (tc) next_state = ST_S2;
            ST_S2:     if (tc) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        isa_chrdy   = 1'b0;
        rsp_valid   = 1'b0;
        cb_addr     = '0;
        cb_func     = '0;
        cb_data_out = '0;
        cb_data_oe  = 1'b0;
        cb_s1       = 1'b0;
        cb_s2       = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                isa_chrdy = 1'b1;
            end
            ST_SETUP, ST_WAIT_X, ST_S1, ST_GAP, ST_S2: begin
                cb_addr     = addr_q;
                cb_func     = func_q;
                cb_data_oe  = write_q;
                cb_data_out = write_q ? wdata_q : '0;
                cb_s1       = (state == ST_S1);
                cb_s2       = (state == ST_S2);
            end
            ST_DONE: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // The timer restarts on every state change with the new state's duration.
    always_comb begin
        tmr_load_en = (next_state != state);
        case (next_state)
            ST_SETUP:  tmr_load_value = tmr_load(T_SETUP);
            ST_WAIT_X: tmr_load_value = tmr_load(TIMEOUT);
            ST_S1:     tmr_load_value = tmr_load(T_S1);
            ST_GAP:    tmr_load_value = tmr_load(T_GAP);
            ST_S2:     tmr_load_value = tmr_load(T_S2);
            default:   tmr_load_value = '0;
        endcase
    end

    camac_cycle_timer u_timer (
        .clk        (isa_clk),
        .rst_n      (isa_reset),
        .load       (tmr_load_en),
        .dec        (state != ST_IDLE),
        .load_value (tmr_load_value),
        .tc         (tc)
    );

`ifdef CAMAC_SEQ_TIMEOUT_EN
    logic timeout_q;
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Response fields clear on accept and then hold from capture until the next accept.
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            addr_q    <= '0;
            func_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rsp_rdata <= '0;
            rsp_x     <= 1'b0;
            rsp_q     <= 1'b0;
`ifdef CAMAC_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else if (accept) begin
            addr_q    <= {req_crate, req_station, req_subaddr};
            func_q    <= req_func;
            wdata_q   <= req_wdata;
            write_q   <= req_write;
            rsp_rdata <= '0;
            rsp_x     <= 1'b0;
            rsp_q     <= 1'b0;
`ifdef CAMAC_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else if ((state == ST_S1) && tc) begin
            rsp_rdata <= write_q ? '0 : cb_data_in;
            rsp_x     <= 1'b1;
            rsp_q     <= ~cb_zk4;
        end
`ifdef CAMAC_SEQ_TIMEOUT_EN
        else if ((state == ST_WAIT_X) && cb_prr && tc) begin
            timeout_q <= 1'b1;
        end
`endif
    end

endmodule
